// File: rtl/serial_adder_unit_if.sv
// rtl/serial_adder_unit_if.sv - start/busy/done operand and result bundle for serial_adder_unit
//
// Purpose: groups the operation request (start, a, b, cin) and the result
// (busy, done, sum, cout, optional ovf) of the serial adder.
// Optional port ovf exists only when SERIAL_ADDER_OVF_EN is defined.
// Modports:
//   master - requester: drives start/a/b/cin, observes busy/done/sum/cout[/ovf]
//   slave  - adder:     observes start/a/b/cin, drives busy/done/sum/cout[/ovf]

interface serial_adder_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_unit.sv
// rtl/serial_adder_unit.sv - digit-serial adder: {cout,sum} = a + b + cin, DIGIT bits per clock
//
// Purpose: adds two WIDTH-bit operands plus carry-in over NDIG = WIDTH/DIGIT
// clocks using one DIGIT-bit adder slice. Operands are captured when start is
// seen while idle; done pulses for one cycle when sum/cout are updated.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed overflow flag ovf.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - serial_adder_unit_if.slave: start, a, b, cin in; busy, done, sum, cout[, ovf] out

module serial_adder_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_unit_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   res;
    logic               carry;

    logic               busy_c;
    logic               accept;
    logic               last;

    logic [DIGIT:0]       slice;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]     res_nx;

    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
    logic               ovf_nx;
`endif

    // The single shared slice: low digit of each operand plus the running carry.
    assign slice = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // New digit enters the result register from the top, so after NDIG steps
    // the first (least significant) digit has reached bit 0.
    assign res_cat = {slice[DIGIT-1:0], res};
    assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB is recovered as a^b^s at the MSB of the final digit.
    assign ovf_nx = opa[DIGIT-1] ^ opb[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_c = 1'b0;
        accept = 1'b0;
        last   = 1'b0;
        case (state)
            IDLE:    accept = bus.start;
            RUN: begin
                busy_c = 1'b1;
                last   = (cnt == LAST);
            end
            default: ;
        endcase
    end

    // Datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            done_q <= last;
            if (accept) begin
                opa   <= bus.a;
                opb   <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end else if (busy_c) begin
                opa   <= opa >> DIGIT;
                opb   <= opb >> DIGIT;
                res   <= res_nx;
                carry <= slice[DIGIT];
                // Holds at LAST so the counter never wraps while idle.
                if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end
                if (last) begin
                    sum_q  <= res_nx;
                    cout_q <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_q  <= ovf_nx;
`endif
                end
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_unit.sv
// tb/tb_serial_adder_unit.sv - scoreboard bench for serial_adder_unit (DIGIT 2, 1, 4, 8 at WIDTH 8)

module tb_serial_adder_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // index 0: DIGIT=2 (main), 1: DIGIT=1, 2: DIGIT=4, 3: DIGIT=8
    serial_adder_unit_if #(.WIDTH(8)) if2 ();
    serial_adder_unit_if #(.WIDTH(8)) if1 ();
    serial_adder_unit_if #(.WIDTH(8)) if4 ();
    serial_adder_unit_if #(.WIDTH(8)) if8 ();

    serial_adder_unit #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    serial_adder_unit #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder_unit #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_adder_unit #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    exp_t q [4][$];
    int   ndig [4] = '{4, 8, 2, 1};

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t sweep [6] = '{
        '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1},
        '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0},
        '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0},
        '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0},
        '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0}
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int k, input logic d, input logic [7:0] s, input logic co);
        exp_t e;
        logic ov;
        if (rst || !d) return;
        ov = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        case (k)
            0: ov = if2.ovf;
            1: ov = if1.ovf;
            2: ov = if4.ovf;
            default: ov = if8.ovf;
        endcase
`endif
        if (q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done[%0d]: got done=1 expected no pending result", k);
        end else begin
            e = q[k].pop_front();
            chk($sformatf("sum[%0d]", k), {24'd0, s}, {24'd0, e.sum});
            chk($sformatf("cout[%0d]", k), {31'd0, co}, {31'd0, e.cout});
            chk($sformatf("latency[%0d]", k), cyc - e.acc, ndig[k]);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("ovf[%0d]", k), {31'd0, ov}, {31'd0, e.ovf});
`else
            if (ov !== 1'b0) $display("note: unexpected ovf value");
`endif
        end
    endtask

    always @(negedge clk) mon(0, if2.done, if2.sum, if2.cout);
    always @(negedge clk) mon(1, if1.done, if1.sum, if1.cout);
    always @(negedge clk) mon(2, if4.done, if4.sum, if4.cout);
    always @(negedge clk) mon(3, if8.done, if8.sum, if8.cout);

    // Called at a negedge; the following posedge is the accept edge.
    task automatic issue(input bit all, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
        if2.a = a; if2.b = b; if2.cin = c; if2.start = 1'b1;
        q[0].push_back(e);
        if (all) begin
            if1.a = a; if1.b = b; if1.cin = c; if1.start = 1'b1;
            if4.a = a; if4.b = b; if4.cin = c; if4.start = 1'b1;
            if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
            for (int k = 1; k < 4; k++) q[k].push_back(e);
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        if2.start = 1'b0; if1.start = 1'b0; if4.start = 1'b0; if8.start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            if (!if2.busy && !if1.busy && !if4.busy && !if8.busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, (i >= 40)}, 32'd0);
    endtask

    initial begin
        int i;
        if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, if2.busy}, 32'd0);
        chk("rst_done", {31'd0, if2.done}, 32'd0);
        chk("rst_sum", {24'd0, if2.sum}, 32'd0);
        chk("rst_cout", {31'd0, if2.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // carry ripple and carry-in
        issue(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); release_start(); wait_idle();
        issue(0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0); release_start(); wait_idle();
        issue(0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0); release_start(); wait_idle();
        @(negedge clk);

        // reset mid-run: result discarded, no done afterwards
        if2.a = 8'hFF; if2.b = 8'hFF; if2.cin = 1'b1; if2.start = 1'b1;
        release_start();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, if2.busy}, 32'd0);
        chk("midrst_done", {31'd0, if2.done}, 32'd0);
        chk("midrst_sum", {24'd0, if2.sum}, 32'd0);
        chk("midrst_cout", {31'd0, if2.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("midrst_ovf", {31'd0, if2.ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_sum", {24'd0, if2.sum}, 32'd0);

        // start while busy is ignored
        issue(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        release_start();
        @(negedge clk);
        if2.a = 8'h10; if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0; if2.a = 8'h00;
        for (i = 0; i < 10; i++) begin
            if (if2.done) break;
            @(negedge clk);
        end
        chk("done_timeout", {31'd0, (i >= 10)}, 32'd0);

        // back-to-back: restart in the done cycle; sum holds 02 until the new result
        issue(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        release_start();
        chk("done_fall", {31'd0, if2.done}, 32'd0);
        for (i = 0; i < 10 && if2.busy; i++) begin
            chk("sum_hold", {24'd0, if2.sum}, 32'h02);
            @(negedge clk);
        end
        wait_idle();

        // signed overflow cases (sum/cout checked in every build)
        issue(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); release_start(); wait_idle();
        issue(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1); release_start(); wait_idle();

        // sweep across digit sizes
        foreach (sweep[v]) begin
            issue(1, sweep[v].a, sweep[v].b, sweep[v].cin, sweep[v].sum, sweep[v].cout, sweep[v].ovf);
            release_start();
            wait_idle();
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("pending[%0d]", k), q[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
